// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one 16-bit bitwise logic unit (AND/OR/XOR/NOT)
// between N_REQ requesters, with a single registered, back-pressured response.
module logic16_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  input  logic [2*N_REQ-1:0]    req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           txn_count
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {StIdle, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_grant_q;
  logic [15:0]       rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [15:0]       txn_q;

  logic              free;
  logic              grant_any;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   cand;
  logic              accept;
  logic              rsp_fire;
  logic [15:0]       op_a, op_b, op_res;
  logic [1:0]        op_sel;

  assign rsp_valid = (state_q == StResp);
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign free      = (state_q == StIdle) | rsp_fire;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdxW'((32'(last_grant_q) + k) % N_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Gate with rst_n so no requester sees ready while reset is held.
  assign accept    = rst_n & free & grant_any;
  assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

  assign op_a   = req_a[{grant_idx, 4'b0000} +: 16];
  assign op_b   = req_b[{grant_idx, 4'b0000} +: 16];
  assign op_sel = req_op[{grant_idx, 1'b0} +: 2];

  always_comb begin
    op_res = '0;
    case (op_sel)
      2'b00:   op_res = op_a & op_b;
      2'b01:   op_res = op_a | op_b;
      2'b10:   op_res = op_a ^ op_b;
      default: op_res = ~op_a;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = StResp;
    end else if (rsp_fire) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(N_REQ - 1);
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      txn_q        <= '0;
    end else begin
      state_q <= state_d;
      if (rsp_fire) begin
        txn_q <= txn_q + 16'd1;
      end
      if (accept) begin
        rsp_data_q   <= op_res;
        rsp_id_q     <= ID_W'(grant_idx);
        last_grant_q <= grant_idx;
      end
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign txn_count = txn_q;

endmodule

// File: doc/logic16_arbiter.md
Name: logic16_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT) between N_REQ requesters.
- Round-robin arbitration; valid/ready handshake per requester on the input side.
- One registered response channel with backpressure, tagged with the requester index.
- Sits between chapter-01 gate-level logic and the higher-level blocks that need occasional 16-bit bitwise operations.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; combinational, at most one bit high.
- req_a  input  16*N_REQ  operand a; requester i uses bits [16i+15:16i].
- req_b  input  16*N_REQ  operand b; same packing.
- req_op  input  2*N_REQ  opcode; 00 AND, 01 OR, 10 XOR, 11 NOT a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer accept.
- rsp_data  output  16  result.
- rsp_id  output  ID_W  index of the requester that produced rsp_data.
- txn_count  output  16  completed-response counter; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0, txn_count=0.
  - last_grant=N_REQ-1, so requester 0 has first priority; state=IDLE.
  - req_ready is all 0 while rst_n is low.
- States: IDLE (no response held), RESP (rsp_valid=1, holding a result).
- Free condition: free = (state==IDLE) | (rsp_ready & rsp_valid).
- Grant:
  - When free and any req_valid is set, g = first i with req_valid[i], searching from last_grant+1 upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - When not free, req_ready = 0.
- Accept (req_valid[g] & req_ready[g] at a rising edge):
  - rsp_data <= op(a_g, b_g); rsp_id <= g; rsp_valid <= 1.
  - last_grant <= g; state <= RESP.
  - Latency: request accepted at edge N gives rsp_valid high after edge N.
- Response handshake (rsp_valid & rsp_ready at an edge):
  - txn_count increments.
  - If a new accept happens at the same edge, state stays RESP with the new data, enabling back-to-back throughput of 1 per cycle.
  - Otherwise rsp_valid <= 0 and state <= IDLE; rsp_data and rsp_id keep their last values.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id are stable and no request is accepted.
- Requester rules: a requester holds req_valid and its operands stable until it sees req_ready. Dropping req_valid before the grant is legal, and that requester is simply skipped.
- Op rules: NOT ignores b (result = ~a). All ops are purely bitwise, with no carry or width growth.
- Fairness: a continuously requesting requester waits at most N_REQ-1 grants.
- Reset mid-transaction: a pending response is discarded; the next grant after reset goes to requester 0.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- Reset, then req_valid=0001 with a0=16'hA5A5, b0=16'h5A5A, op0=01, rsp_ready=1 -> req_ready=0001 in the same cycle; next cycle rsp_valid=1, rsp_data=16'hFFFF, rsp_id=0, then txn_count=1.
- One request per op on requester 2 with a=16'hF0F0, b=16'hFF00 -> AND 16'hF000, OR 16'hFFF0, XOR 16'h0FF0, NOT 16'h0F0F; rsp_id=2 each time.
- All four valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,…, one rsp_valid per cycle; txn_count=8 after 8 cycles.
- rsp_ready=0 for 5 cycles with requests pending -> req_ready=0, rsp_data/rsp_id frozen; on rsp_ready=1 the next requester is granted in that same cycle.
- Requester 1 drops req_valid before being granted while 0 and 3 hold valid -> grant sequence 0,3,0,3; no response with rsp_id=1.
- Assert rst_n=0 while rsp_valid=1, rsp_ready=0 -> rsp_valid=0 and txn_count=0 immediately, without waiting for a clock edge; after release with all valid, the first grant is requester 0.
